infix_to_postfix: RTL and testbench
===================================

// Module: infix_to_postfix
// PURPOSE
//  Converts a burst of infix tokens (operands, + - *, parentheses) into postfix order using shunting-yard.
//  Re-emits the result as one contiguous IN_VALID-style burst on the postfix evaluator's token interface.
//  Sits directly upstream of the postfix evaluator and drives its IN_VALID/IN/OP_MODE.
//  The output burst is never split, because the evaluator treats a low valid as end-of-expression.
// PARAMETERS
//  OPSTK_DEPTH  8   operator-stack entries (holds +,-,*,'(')
//  BUF_DEPTH    32  postfix token buffer entries (power of 2)
// PORTS
//  CLK        in   1  clock
//  RESET      in   1  synchronous, active-high reset
//  IN_VALID   in   1  infix token valid; one expression = one contiguous high burst
//  IN_MODE    in   1  0 = operand, 1 = operator/paren
//  IN         in   4  operand value, or op code: 0001 +, 0010 -, 0100 *, 1000 '(', 1001 ')'
//  OUT_VALID  out  1  postfix token valid (evaluator IN_VALID)
//  OUT_MODE   out  1  0 = operand, 1 = operator (evaluator OP_MODE)
//  OUT        out  4  postfix token: operand value, or 0001/0010/0100 only
//  BUSY       out  1  high in FLUSH/SEND; input tokens are ignored while high
//  ERR        out  1  one-cycle pulse: expression rejected, no burst sent
// BEHAVIOUR
//  Reset: state IDLE; stack and buffer pointers cleared; OUT_VALID=0, OUT_MODE=0, OUT=0, BUSY=0, ERR=0.
//  RESET mid-operation aborts any expression or burst. OUT_VALID is 0 after that edge.
//  States: IDLE -> COLLECT (first IN_VALID=1 sampled) -> FLUSH (IN_VALID=0 sampled) -> SEND -> IDLE.
//  COLLECT, per token, one token per cycle, no backpressure:
//   - operand: append to buffer.
//   - '*': pop a '*' on top to buffer, then push '*'.
//   - '+'/'-': pop up to two ops ('*' and/or '+'/'-') to buffer, stopping at '(' or empty, then push.
//   - '(': push.
//   - ')': pop up to two ops to buffer, then pop the '(' and discard it.
//  Precedence is two-level and left-associative, so at most 2 ops sit above any '('.
//  Buffer therefore takes <=2 writes per cycle, ordered top-first.
//  FLUSH: each cycle pops one stack entry to the buffer. When the stack is empty, go to SEND.
//   With k ops left, FLUSH lasts k+1 cycles.
//   First OUT_VALID rises on the (k+2)th edge after the last token edge.
//  SEND: OUT_VALID=1 for exactly N consecutive cycles (N = buffer count), with OUT/OUT_MODE = buf[0..N-1].
//   All outputs are registered. After the burst, OUT_VALID=0, OUT=0, OUT_MODE=0, and state returns to IDLE.
//  Errors set a sticky flag; remaining input is absorbed. Error sources:
//   - ')' with no '(' on the stack
//   - '(' reached during FLUSH
//   - operator-stack overflow
//   - buffer overflow
//   - undefined op code
//  With the flag set, FLUSH ends with ERR=1 for one cycle and no SEND. The flag clears on return to IDLE.
//  Operand/operator adjacency is not checked; it is the producer's responsibility.
//  An empty expression is impossible, since a burst contains >=1 token.
//  IN_VALID high while BUSY: tokens dropped, no error. A new burst is accepted only from IDLE.
// STRUCTURE
//  postfix_pkg: token codes (ADD/SUB/MUL/LPAR/RPAR), state encoding, precedence function.
//  Sub-module op_stack: LIFO of OPSTK_DEPTH x 4b.
//   Exposes top and top-1, count, and supports pop0/1/2 combined with push in one cycle, plus overflow/underflow flags.
//  Top level: FSM, buffer (dual-write, single-read) and output registers.
// TESTING
//  3 + 4 * 2 -> burst 3,4,2,*,+ with modes 0,0,0,1,1.
//   5 cycles, OUT_VALID rising on the 4th edge after the last token.
//  ( 3 + 4 ) * 2 -> 3,4,+,2,*. Checks '(' discard; evaluator reference result 14.
//  8 - 2 - 1 -> 8,2,-,1,- (left-assoc). ( 1 + 2 * 3 - 4 ) -> 1,2,3,*,+,4,- (2-op cascade in one cycle).
//  3 + 4 ) -> ERR pulse, OUT_VALID stays 0. ( 3 -> ERR. 9 nested '(' with OPSTK_DEPTH=8 -> ERR.
//  RESET asserted in SEND cycle 2 of 5 -> OUT_VALID=0 after that edge.
//   Then 5 * 5 -> 5,5,* is sent normally.
//  IN_VALID burst 7 during BUSY -> ignored; prior burst unchanged; next burst from IDLE converts correctly.

Source files
------------

// File: rtl/infix_to_postfix_pkg.sv
// Shared definitions for the infix-to-postfix converter.
//   - 4-bit token codes for the operator/paren alphabet
//   - FSM state encoding
//   - op_prec(): two-level operator precedence (0 = not an operator)
package infix_to_postfix_pkg;

   localparam logic [3:0] TOK_ADD  = 4'b0001;
   localparam logic [3:0] TOK_SUB  = 4'b0010;
   localparam logic [3:0] TOK_MUL  = 4'b0100;
   localparam logic [3:0] TOK_LPAR = 4'b1000;
   localparam logic [3:0] TOK_RPAR = 4'b1001;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_FLUSH   = 2'd2,
      ST_SEND    = 2'd3
   } state_t;

   // '(' and ')' rank 0 so that a pop cascade naturally stops at '('.
   function automatic logic [1:0] op_prec(input logic [3:0] tok);
      case (tok)
         TOK_MUL:          op_prec = 2'd2;
         TOK_ADD, TOK_SUB: op_prec = 2'd1;
         default:          op_prec = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/infix_to_postfix_op_stack.sv
// Operator stack: LIFO of DEPTH x 4-bit tokens.
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_clear             synchronous empty (end of expression)
//   i_pop               number of entries to pop this cycle (0..3)
//   i_push, i_push_tok  push one token after the pops, same cycle
//   o_top, o_top1       top and top-1 entries (0 when absent)
//   o_count             current occupancy
//   o_ovf, o_udf        this cycle's request would overflow / underflow;
//                       a faulty request leaves the stack unchanged
module infix_to_postfix_op_stack #(
   parameter int DEPTH = 8
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_clear,
   input  logic [1:0]                   i_pop,
   input  logic                         i_push,
   input  logic [3:0]                   i_push_tok,
   output logic [3:0]                   o_top,
   output logic [3:0]                   o_top1,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_ovf,
   output logic                         o_udf
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(DEPTH);

   logic [3:0]    r_mem [DEPTH];
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_base;
   logic [CW-1:0] w_i0;
   logic [CW-1:0] w_i1;
   logic          w_ok;

   assign w_i0    = r_count - CW'(1);
   assign w_i1    = r_count - CW'(2);
   assign o_top   = (r_count >= CW'(1)) ? r_mem[w_i0[IW-1:0]] : 4'd0;
   assign o_top1  = (r_count >= CW'(2)) ? r_mem[w_i1[IW-1:0]] : 4'd0;
   assign o_count = r_count;

   // The push lands in the slot freed by the pops of the same cycle.
   assign o_udf  = CW'(i_pop) > r_count;
   assign w_base = r_count - CW'(i_pop);
   assign o_ovf  = i_push && !o_udf && (w_base == CW'(DEPTH));
   assign w_ok   = !o_udf && !o_ovf;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_count <= '0;
      end else if (w_ok) begin
         r_count <= w_base + CW'(i_push);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_push && w_ok && !i_clear) begin
         r_mem[w_base[IW-1:0]] <= i_push_tok;
      end
   end

endmodule

// File: rtl/infix_to_postfix.sv
// Shunting-yard converter: collects one infix burst, then re-emits it in
// postfix order as a single unbroken valid burst for the postfix evaluator.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_in_valid       infix token valid; one expression = one high burst
//   i_in_mode        0 operand, 1 operator/paren
//   i_in             operand value or op code (+ - * ( ))
//   o_out_valid      postfix token valid
//   o_out_mode       0 operand, 1 operator
//   o_out            postfix token
//   o_busy           high in FLUSH/SEND; input is dropped while high
//   o_err            one-cycle pulse: expression rejected, nothing sent
//   o_dbg_state      current FSM state
// Handshake: no backpressure either way. A token is taken on every edge where
// i_in_valid is high in IDLE/COLLECT; the first low ends the expression. The
// output burst holds o_out_valid high for exactly N consecutive cycles, since
// the consumer reads a low valid as end-of-expression.
module infix_to_postfix
   import infix_to_postfix_pkg::*;
#(
   parameter int OPSTK_DEPTH = 8,
   parameter int BUF_DEPTH   = 32
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_in_valid,
   input  logic       i_in_mode,
   input  logic [3:0] i_in,
   output logic       o_out_valid,
   output logic       o_out_mode,
   output logic [3:0] o_out,
   output logic       o_busy,
   output logic       o_err,
   output logic [1:0] o_dbg_state
);

   localparam int SCW = $clog2(OPSTK_DEPTH + 1);
   localparam int BAW = $clog2(BUF_DEPTH);
   localparam int BCW = BAW + 1;
   localparam int BXW = BCW + 1;

   state_t         r_state, w_next;
   logic [4:0]     r_buf [BUF_DEPTH];   // {mode, token}
   logic [BCW-1:0] r_wr_cnt;
   logic [BCW-1:0] r_rd_ptr;
   logic           r_err_flag;
   logic           r_out_valid;
   logic           r_out_mode;
   logic [3:0]     r_out;
   logic           r_err;

   logic [3:0]     w_top, w_top1;
   logic [SCW-1:0] w_count;
   logic           w_ovf, w_udf;
   logic           w_fire;
   logic [1:0]     w_in_prec;
   logic [1:0]     w_n_ops;
   logic [1:0]     w_pop;
   logic           w_push;
   logic [3:0]     w_push_tok;
   logic [1:0]     w_wr_n;
   logic [4:0]     w_wr0, w_wr1;
   logic [BAW-1:0] w_wa0, w_wa1;
   logic           w_bad_code;
   logic           w_lpar_err;
   logic           w_buf_ovf;
   logic           w_set_err;
   logic           w_err_pulse;
   logic           w_to_idle;
   logic           w_load;

   infix_to_postfix_op_stack #(.DEPTH(OPSTK_DEPTH)) u_stack (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_clear    (w_to_idle),
      .i_pop      (w_pop),
      .i_push     (w_push),
      .i_push_tok (w_push_tok),
      .o_top      (w_top),
      .o_top1     (w_top1),
      .o_count    (w_count),
      .o_ovf      (w_ovf),
      .o_udf      (w_udf)
   );

   assign w_fire = i_in_valid && !r_err_flag &&
                   ((r_state == ST_IDLE) || (r_state == ST_COLLECT));

   // Ops on the stack that must leave before the incoming token. ')' acts
   // like a '+' here: it flushes every operator down to the '('.
   always_comb begin
      w_in_prec = (i_in == TOK_RPAR) ? 2'd1 : op_prec(i_in);
      w_n_ops   = 2'd0;
      if ((w_count != '0) && (op_prec(w_top) != 2'd0) &&
          (op_prec(w_top) >= w_in_prec)) begin
         w_n_ops = 2'd1;
         if ((w_count > SCW'(1)) && (op_prec(w_top1) != 2'd0) &&
             (op_prec(w_top1) >= w_in_prec)) begin
            w_n_ops = 2'd2;
         end
      end
   end

   // Stack and buffer control for COLLECT tokens and FLUSH pops.
   always_comb begin
      w_pop      = 2'd0;
      w_push     = 1'b0;
      w_push_tok = 4'd0;
      w_wr_n     = 2'd0;
      w_wr0      = {1'b1, w_top};
      w_wr1      = {1'b1, w_top1};
      w_bad_code = 1'b0;
      w_lpar_err = 1'b0;
      if (w_fire) begin
         if (!i_in_mode) begin
            w_wr_n = 2'd1;
            w_wr0  = {1'b0, i_in};
         end else begin
            case (i_in)
               TOK_ADD, TOK_SUB, TOK_MUL: begin
                  w_pop      = w_n_ops;
                  w_wr_n     = w_n_ops;
                  w_push     = 1'b1;
                  w_push_tok = i_in;
               end
               TOK_LPAR: begin
                  w_push     = 1'b1;
                  w_push_tok = TOK_LPAR;
               end
               TOK_RPAR: begin
                  // The extra pop removes the '('; with none present the
                  // stack reports underflow.
                  w_pop  = w_n_ops + 2'd1;
                  w_wr_n = w_n_ops;
               end
               default: w_bad_code = 1'b1;
            endcase
         end
      end else if ((r_state == ST_FLUSH) && !r_err_flag && (w_count != '0)) begin
         w_pop = 2'd1;
         if (w_top == TOK_LPAR) begin
            w_lpar_err = 1'b1;
         end else begin
            w_wr_n = 2'd1;
         end
      end
   end

   assign w_buf_ovf = ({1'b0, r_wr_cnt} + BXW'(w_wr_n)) > BXW'(BUF_DEPTH);
   assign w_set_err = w_bad_code | w_lpar_err | w_ovf | w_udf | w_buf_ovf;

   // Next state.
   always_comb begin
      w_next      = r_state;
      w_err_pulse = 1'b0;
      case (r_state)
         ST_IDLE:    if (w_fire) w_next = ST_COLLECT;
         ST_COLLECT: if (!i_in_valid) w_next = ST_FLUSH;
         ST_FLUSH: begin
            if (r_err_flag) begin
               w_next      = ST_IDLE;
               w_err_pulse = 1'b1;
            end else if (w_count == '0) begin
               w_next = (r_wr_cnt == '0) ? ST_IDLE : ST_SEND;
            end
         end
         ST_SEND:    if (r_rd_ptr == r_wr_cnt) w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   assign w_to_idle = (r_state != ST_IDLE) && (w_next == ST_IDLE);
   assign w_load    = (w_next == ST_SEND);
   assign w_wa0     = r_wr_cnt[BAW-1:0];
   assign w_wa1     = w_wa0 + BAW'(1);

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= ST_IDLE;
      else         r_state <= w_next;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_cnt    <= '0;
         r_rd_ptr    <= '0;
         r_err_flag  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_mode  <= 1'b0;
         r_out       <= 4'd0;
         r_err       <= 1'b0;
      end else begin
         r_err <= w_err_pulse;
         if (w_to_idle) begin
            r_wr_cnt   <= '0;
            r_err_flag <= 1'b0;
         end else begin
            r_wr_cnt <= r_wr_cnt + BCW'(w_wr_n);
            if (w_set_err) r_err_flag <= 1'b1;
         end
         if (w_load) begin
            r_out_valid              <= 1'b1;
            {r_out_mode, r_out}      <= r_buf[r_rd_ptr[BAW-1:0]];
            r_rd_ptr                 <= r_rd_ptr + BCW'(1);
         end else begin
            r_out_valid <= 1'b0;
            r_out_mode  <= 1'b0;
            r_out       <= 4'd0;
            r_rd_ptr    <= '0;
         end
      end
   end

   // Dual write port: popped ops go in top-first order.
   always_ff @(posedge i_clk) begin
      if (w_wr_n != 2'd0) r_buf[w_wa0] <= w_wr0;
      if (w_wr_n == 2'd2) r_buf[w_wa1] <= w_wr1;
   end

   assign o_out_valid = r_out_valid;
   assign o_out_mode  = r_out_mode;
   assign o_out       = r_out;
   assign o_err       = r_err;
   assign o_busy      = (r_state == ST_FLUSH) || (r_state == ST_SEND);
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_infix_to_postfix.sv
module tb_infix_to_postfix;

   localparam logic [3:0] T_ADD = 4'b0001;
   localparam logic [3:0] T_SUB = 4'b0010;
   localparam logic [3:0] T_MUL = 4'b0100;
   localparam logic [3:0] T_LP  = 4'b1000;
   localparam logic [3:0] T_RP  = 4'b1001;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_mode = 1'b0;
   logic [3:0] in_tok = 4'd0;
   logic       out_valid, out_mode, busy, err;
   logic [3:0] out_tok;
   logic [1:0] dbg;

   always #5 clk = ~clk;

   infix_to_postfix #(.OPSTK_DEPTH(8), .BUF_DEPTH(32)) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_in_valid  (in_valid),
      .i_in_mode   (in_mode),
      .i_in        (in_tok),
      .o_out_valid (out_valid),
      .o_out_mode  (out_mode),
      .o_out       (out_tok),
      .o_busy      (busy),
      .o_err       (err),
      .o_dbg_state (dbg)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   // ---------------- monitor / scoreboard storage ----------------
   logic [4:0] in_q[$];
   logic [4:0] exp_q[$];
   logic [4:0] got_q[$];
   int n_rise = 0;
   int n_err = 0;
   int rise_edge = 0;
   int last_edge = 0;
   logic prev_v = 1'b0;

   always @(negedge clk) begin
      if (out_valid) got_q.push_back({out_mode, out_tok});
      if (out_valid && !prev_v) begin
         n_rise++;
         rise_edge = cyc;
      end
      if (err) n_err++;
      prev_v = out_valid;
   end

   // ---------------- driver tasks ----------------
   task opnd(input logic [3:0] v);
      in_q.push_back({1'b0, v});
   endtask

   task oper(input logic [3:0] c);
      in_q.push_back({1'b1, c});
   endtask

   task drive_burst();
      for (int i = 0; i < in_q.size(); i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_mode  = in_q[i][4];
         in_tok   = in_q[i][3:0];
      end
      @(posedge clk); #1;
      last_edge = cyc;
      in_valid  = 1'b0;
      in_mode   = 1'b0;
      in_tok    = 4'd0;
      in_q.delete();
   endtask

   task settle();
      repeat (45) @(negedge clk);
   endtask

   function automatic logic [79:0] pack_got(input int g0);
      logic [79:0] v = '0;
      for (int i = g0; i < got_q.size(); i++) v = {v[74:0], got_q[i]};
      return v;
   endfunction

   function automatic logic [79:0] pack_exp();
      logic [79:0] v = '0;
      for (int i = 0; i < exp_q.size(); i++) v = {v[74:0], exp_q[i]};
      return v;
   endfunction

   // Reference postfix evaluator over the captured burst.
   function automatic int eval_pf(input int g0);
      int st[$];
      int a, b;
      for (int i = g0; i < got_q.size(); i++) begin
         if (got_q[i][4] == 1'b0) begin
            st.push_back(int'(got_q[i][3:0]));
         end else begin
            if (st.size() < 2) return -999;
            b = st.pop_back();
            a = st.pop_back();
            case (got_q[i][3:0])
               4'b0001: st.push_back(a + b);
               4'b0010: st.push_back(a - b);
               4'b0100: st.push_back(a * b);
               default: return -999;
            endcase
         end
      end
      return (st.size() == 1) ? st[0] : -999;
   endfunction

   // ---------------- tests ----------------
   task test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({out_valid, out_mode, out_tok, busy, err} !== 8'h00) begin
         bad++;
         $display("FAIL reset_outputs got=%h exp=00", {out_valid, out_mode, out_tok, busy, err});
      end
      total++;
      if (dbg !== 2'd0) begin
         bad++;
         $display("FAIL reset_state got=%0d exp=0", dbg);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task test_precedence();
      int g0, r0, e0;
      g0 = got_q.size(); r0 = n_rise; e0 = n_err;
      opnd(3); oper(T_ADD); opnd(4); oper(T_MUL); opnd(2);
      exp_q = {5'h03, 5'h04, 5'h02, 5'h14, 5'h11};
      drive_burst();
      settle();
      total++;
      if (got_q.size() - g0 !== exp_q.size()) begin
         bad++; $display("FAIL prec_len got=%0d exp=%0d", got_q.size() - g0, exp_q.size());
      end
      total++;
      if (pack_got(g0) !== pack_exp()) begin
         bad++; $display("FAIL prec_seq got=%h exp=%h", pack_got(g0), pack_exp());
      end
      total++;
      if (n_rise - r0 !== 1 || n_err - e0 !== 0) begin
         bad++; $display("FAIL prec_burst rises=%0d errs=%0d exp=1,0", n_rise - r0, n_err - e0);
      end
      total++;
      if (rise_edge - last_edge !== 4) begin
         bad++; $display("FAIL prec_latency got=%0d exp=4", rise_edge - last_edge);
      end
      total++;
      if (eval_pf(g0) !== 11) begin
         bad++; $display("FAIL prec_eval got=%0d exp=11", eval_pf(g0));
      end
   endtask

   task test_paren();
      int g0;
      g0 = got_q.size();
      oper(T_LP); opnd(3); oper(T_ADD); opnd(4); oper(T_RP); oper(T_MUL); opnd(2);
      exp_q = {5'h03, 5'h04, 5'h11, 5'h02, 5'h14};
      drive_burst();
      settle();
      total++;
      if (pack_got(g0) !== pack_exp() || got_q.size() - g0 !== 5) begin
         bad++; $display("FAIL paren_seq got=%h exp=%h", pack_got(g0), pack_exp());
      end
      total++;
      if (rise_edge - last_edge !== 3) begin
         bad++; $display("FAIL paren_latency got=%0d exp=3", rise_edge - last_edge);
      end
      total++;
      if (eval_pf(g0) !== 14) begin
         bad++; $display("FAIL paren_eval got=%0d exp=14", eval_pf(g0));
      end
   endtask

   task test_left_assoc();
      int g0;
      g0 = got_q.size();
      opnd(8); oper(T_SUB); opnd(2); oper(T_SUB); opnd(1);
      exp_q = {5'h08, 5'h02, 5'h12, 5'h01, 5'h12};
      drive_burst();
      settle();
      total++;
      if (pack_got(g0) !== pack_exp() || got_q.size() - g0 !== 5) begin
         bad++; $display("FAIL assoc_seq got=%h exp=%h", pack_got(g0), pack_exp());
      end
      total++;
      if (eval_pf(g0) !== 5) begin
         bad++; $display("FAIL assoc_eval got=%0d exp=5", eval_pf(g0));
      end
   endtask

   task test_cascade();
      int g0;
      g0 = got_q.size();
      oper(T_LP); opnd(1); oper(T_ADD); opnd(2); oper(T_MUL); opnd(3);
      oper(T_SUB); opnd(4); oper(T_RP);
      exp_q = {5'h01, 5'h02, 5'h03, 5'h14, 5'h11, 5'h04, 5'h12};
      drive_burst();
      settle();
      total++;
      if (pack_got(g0) !== pack_exp() || got_q.size() - g0 !== 7) begin
         bad++; $display("FAIL cascade_seq got=%h exp=%h", pack_got(g0), pack_exp());
      end
      total++;
      if (rise_edge - last_edge !== 2) begin
         bad++; $display("FAIL cascade_latency got=%0d exp=2", rise_edge - last_edge);
      end
   endtask

   task test_stack_full();
      int g0, e0;
      g0 = got_q.size(); e0 = n_err;
      for (int i = 0; i < 8; i++) oper(T_LP);
      opnd(1);
      for (int i = 0; i < 8; i++) oper(T_RP);
      drive_burst();
      settle();
      total++;
      if (got_q.size() - g0 !== 1 || n_err - e0 !== 0) begin
         bad++; $display("FAIL stack_full len=%0d errs=%0d exp=1,0", got_q.size() - g0, n_err - e0);
      end else begin
         total++;
         if (got_q[g0] !== 5'h01) begin
            bad++; $display("FAIL stack_full_tok got=%h exp=01", got_q[g0]);
         end
      end
   endtask

   task test_buffer_full();
      int g0, e0;
      g0 = got_q.size(); e0 = n_err;
      for (int i = 0; i < 32; i++) opnd(4'(i));
      drive_burst();
      settle();
      total++;
      if (got_q.size() - g0 !== 32 || n_err - e0 !== 0) begin
         bad++; $display("FAIL buf_full len=%0d errs=%0d exp=32,0", got_q.size() - g0, n_err - e0);
      end else begin
         total++;
         if (got_q[g0 + 17] !== 5'h01 || got_q[g0 + 31] !== 5'h0f) begin
            bad++; $display("FAIL buf_full_tok got=%h,%h exp=01,0f", got_q[g0 + 17], got_q[g0 + 31]);
         end
      end
   endtask

   // Tokens are queued in in_q by the caller.
   task test_error(input string name);
      int g0, e0;
      g0 = got_q.size(); e0 = n_err;
      drive_burst();
      settle();
      total++;
      if (n_err - e0 !== 1) begin
         bad++; $display("FAIL err_%s pulses got=%0d exp=1", name, n_err - e0);
      end
      total++;
      if (got_q.size() - g0 !== 0) begin
         bad++; $display("FAIL err_%s_out tokens got=%0d exp=0", name, got_q.size() - g0);
      end
   endtask

   task test_reset_mid_send();
      int g0;
      g0 = got_q.size();
      opnd(3); oper(T_ADD); opnd(4); oper(T_MUL); opnd(2);
      drive_burst();
      for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
      total++;
      if (!out_valid) begin
         bad++; $display("FAIL rst_send_timeout got=0 exp=1");
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || dbg !== 2'd0) begin
         bad++; $display("FAIL rst_send_abort valid=%b busy=%b st=%0d exp=0,0,0", out_valid, busy, dbg);
      end
      rst = 1'b0;
      settle();
      total++;
      if (got_q.size() - g0 !== 2) begin
         bad++; $display("FAIL rst_send_len got=%0d exp=2", got_q.size() - g0);
      end
      g0 = got_q.size();
      opnd(5); oper(T_MUL); opnd(5);
      exp_q = {5'h05, 5'h05, 5'h14};
      drive_burst();
      settle();
      total++;
      if (pack_got(g0) !== pack_exp() || got_q.size() - g0 !== 3) begin
         bad++; $display("FAIL rst_after_seq got=%h exp=%h", pack_got(g0), pack_exp());
      end
      total++;
      if (eval_pf(g0) !== 25) begin
         bad++; $display("FAIL rst_after_eval got=%0d exp=25", eval_pf(g0));
      end
   endtask

   task test_busy_drop();
      int g0, r0, e0;
      g0 = got_q.size(); r0 = n_rise; e0 = n_err;
      opnd(3); oper(T_ADD); opnd(4); oper(T_MUL); opnd(2);
      exp_q = {5'h03, 5'h04, 5'h02, 5'h14, 5'h11};
      drive_burst();
      for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
      total++;
      if (!busy) begin
         bad++; $display("FAIL busy_timeout got=0 exp=1");
      end
      @(posedge clk); #1;
      in_valid = 1'b1; in_mode = 1'b0; in_tok = 4'd7;
      @(posedge clk); #1;
      in_valid = 1'b0; in_tok = 4'd0;
      settle();
      total++;
      if (pack_got(g0) !== pack_exp() || got_q.size() - g0 !== 5) begin
         bad++; $display("FAIL busy_seq got=%h exp=%h", pack_got(g0), pack_exp());
      end
      total++;
      if (n_rise - r0 !== 1 || n_err - e0 !== 0) begin
         bad++; $display("FAIL busy_burst rises=%0d errs=%0d exp=1,0", n_rise - r0, n_err - e0);
      end
      g0 = got_q.size();
      opnd(7);
      drive_burst();
      settle();
      total++;
      if (got_q.size() - g0 !== 1) begin
         bad++; $display("FAIL busy_next_len got=%0d exp=1", got_q.size() - g0);
      end else begin
         total++;
         if (got_q[g0] !== 5'h07) begin
            bad++; $display("FAIL busy_next_tok got=%h exp=07", got_q[g0]);
         end
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_precedence();
      test_paren();
      test_left_assoc();
      test_cascade();
      test_stack_full();
      test_buffer_full();
      opnd(3); oper(T_ADD); opnd(4); oper(T_RP);
      test_error("unmatched_rpar");
      oper(T_LP); opnd(3);
      test_error("open_lpar");
      for (int i = 0; i < 9; i++) oper(T_LP);
      opnd(1);
      test_error("stack_ovf");
      opnd(3); oper(4'b0011); opnd(4);
      test_error("bad_code");
      for (int i = 0; i < 33; i++) opnd(4'd1);
      test_error("buf_ovf");
      test_reset_mid_send();
      test_busy_drop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
